// File: rtl/aq_f_spsram_1024x64_ctrl.sv
// Request-side controller for the 1024x64 single-port SRAM macro: drives the
// active-low macro pins, zero-fills after reset and buffers read data in a FIFO.
`timescale 1ns/1ps
module aq_f_spsram_1024x64_ctrl #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 64,
    parameter int RSP_DEPTH  = 4,
    parameter int INIT_EN    = 1
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      req_vld,
    output logic                      req_rdy,
    input  logic                      req_wr,
    input  logic [ADDR_WIDTH-1:0]     req_addr,
    input  logic [DATA_WIDTH-1:0]     req_wdata,
    input  logic [DATA_WIDTH/8-1:0]   req_wstrb,
    output logic                      rsp_vld,
    input  logic                      rsp_rdy,
    output logic [DATA_WIDTH-1:0]     rsp_data,
    output logic                      init_done,
    output logic [ADDR_WIDTH-1:0]     sram_a,
    output logic                      sram_cen,
    output logic                      sram_gwen,
    output logic [DATA_WIDTH-1:0]     sram_wen,
    output logic [DATA_WIDTH-1:0]     sram_d,
    input  logic [DATA_WIDTH-1:0]     sram_q
);

    localparam int BW  = DATA_WIDTH / 8;
    localparam int PW  = $clog2(RSP_DEPTH);
    localparam int CW  = PW + 1;
    localparam int CW1 = CW + 1;

    typedef enum logic {ST_INIT, ST_RUN} state_e;
    localparam state_e RST_ST = (INIT_EN != 0) ? ST_INIT : ST_RUN;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
    logic                  init_done_q, init_done_d;
    logic                  rd_pend_q, rd_pend_d;

    logic [DATA_WIDTH-1:0] fifo_q [RSP_DEPTH];
    logic [PW-1:0]         wptr_q, rptr_q;
    logic [CW-1:0]         fcnt_q;

    logic fire, push, pop, credit_ok;

    // In-flight reads hold a slot; a pop in the same cycle is deliberately not credited.
    assign credit_ok = (CW1'(fcnt_q) + CW1'(rd_pend_q)) < CW1'(RSP_DEPTH);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        req_rdy   = 1'b0;
        fire      = 1'b0;
        sram_cen  = 1'b1;
        sram_gwen = 1'b1;
        sram_wen  = '1;
        sram_a    = '0;
        sram_d    = '0;
        // Pins are gated by RST so the macro is idle the instant reset asserts.
        case (state_q)
            ST_INIT: begin
                if (!RST) begin
                    sram_cen  = 1'b0;
                    sram_gwen = 1'b0;
                    sram_wen  = '0;
                    sram_a    = cnt_q;
                    cnt_d     = cnt_q + ADDR_WIDTH'(1);
                    if (cnt_q == '1) begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                req_rdy = ~RST & (req_wr | credit_ok);
                fire    = req_vld & req_rdy;
                if (fire) begin
                    sram_cen  = 1'b0;
                    sram_gwen = ~req_wr;
                    sram_a    = req_addr;
                    sram_d    = req_wdata;
                    for (int unsigned i = 0; i < BW; i++) begin
                        sram_wen[i*8 +: 8] = {8{~(req_wr & req_wstrb[i])}};
                    end
                end
            end
            default: state_d = RST_ST;
        endcase
        init_done_d = (state_d == ST_RUN);
        rd_pend_d   = fire & ~req_wr;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= RST_ST;
            cnt_q       <= '0;
            init_done_q <= 1'b0;
            rd_pend_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            init_done_q <= init_done_d;
            rd_pend_q   <= rd_pend_d;
        end
    end

    assign push = rd_pend_q;
    assign pop  = rsp_vld & rsp_rdy;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wptr_q <= '0;
            rptr_q <= '0;
            fcnt_q <= '0;
            for (int unsigned i = 0; i < RSP_DEPTH; i++) begin
                fifo_q[i] <= '0;
            end
        end else begin
            if (push) begin
                fifo_q[wptr_q] <= sram_q;
                wptr_q         <= wptr_q + PW'(1);
            end
            if (pop) begin
                rptr_q <= rptr_q + PW'(1);
            end
            case ({push, pop})
                2'b10:   fcnt_q <= fcnt_q + CW'(1);
                2'b01:   fcnt_q <= fcnt_q - CW'(1);
                default: fcnt_q <= fcnt_q;
            endcase
        end
    end

    assign rsp_vld   = (fcnt_q != '0);
    assign rsp_data  = fifo_q[rptr_q];
    assign init_done = init_done_q;

endmodule

// File: doc/aq_f_spsram_1024x64_ctrl.md
Name: aq_f_spsram_1024x64_ctrl

Overview:
Request-side controller for the 1024x64 single-port FPGA SRAM macro. It accepts valid/ready read and write requests and drives the macro's active-low CEN, GWEN and per-bit WEN pins. It captures one-cycle-latency read data into a response FIFO with a valid/ready response channel. After reset it can optionally zero-fill the whole array before accepting traffic.

Parameters:
ADDR_WIDTH, 10, SRAM address width (depth = 2^ADDR_WIDTH)
DATA_WIDTH, 64, SRAM data width; must be a multiple of 8
RSP_DEPTH, 4, response FIFO entries (power of 2, >=2)
INIT_EN, 1, 1 = zero-fill array after reset; 0 = enter RUN directly

Ports:
CLK  in  1  clock
RST  in  1  asynchronous active-high reset
req_vld  in  1  request valid
req_rdy  out  1  request ready
req_wr  in  1  1 = write, 0 = read
req_addr  in  ADDR_WIDTH  word address
req_wdata  in  DATA_WIDTH  write data
req_wstrb  in  DATA_WIDTH/8  byte enables, active-high
rsp_vld  out  1  read data valid
rsp_rdy  in  1  response accepted
rsp_data  out  DATA_WIDTH  read data
init_done  out  1  high once zero-fill is complete and the block is in RUN
sram_a  out  ADDR_WIDTH  to macro A
sram_cen  out  1  to macro CEN, active-low
sram_gwen  out  1  to macro GWEN, active-low write
sram_wen  out  DATA_WIDTH  to macro WEN, active-low bit write enables
sram_d  out  DATA_WIDTH  to macro D
sram_q  in  DATA_WIDTH  from macro Q, valid the cycle after a read

Behaviour:
- Clock and reset: one clock CLK; reset RST is asynchronous and active-high.
- State machine: INIT, RUN.
  - Reset enters INIT if INIT_EN=1, otherwise RUN.
  - RST asserted in any state returns the block to its reset state. Pending reads and FIFO contents are discarded.
- Reset values:
  - req_rdy=0, rsp_vld=0, rsp_data=0, init_done=0.
  - sram_cen=1, sram_gwen=1, sram_wen=all 1s, sram_a=0, sram_d=0.
  - Init counter = 0, FIFO empty, rd_pend = 0.
- INIT:
  - Each cycle drives cen=0, gwen=0, wen=0, d=0, a=counter, then increments the counter.
  - After address 2^ADDR_WIDTH-1 is written, transition to RUN. That is 1024 cycles by default.
  - req_rdy=0 throughout INIT.
  - init_done is a register and rises on the first RUN cycle.
- RUN, request handshake (fire = req_vld & req_rdy):
  - Writes: req_rdy=1 unconditionally.
  - Reads: req_rdy = (fifo_cnt + rd_pend) < RSP_DEPTH. A same-cycle pop is not credited.
  - req_rdy may depend on req_wr combinationally. req_vld must not depend on req_rdy.
- SRAM drive:
  - SRAM pins are combinational from the request in the fire cycle.
  - cen = ~fire.
  - gwen = ~(fire & req_wr).
  - a = req_addr.
  - d = req_wdata.
  - wen[i] = ~(req_wr & req_wstrb[i/8]).
  - With no fire: cen=1, gwen=1, wen all 1s, a=0, d=0.
  - A write with all-zero wstrb still asserts cen and gwen but changes nothing.
- Read pipeline:
  - A read fire sets rd_pend=1 for the next cycle.
  - In that next cycle sram_q is pushed into the FIFO at the closing edge.
  - rsp_vld therefore rises 2 cycles after the read fire.
  - Responses are returned in request order.
  - Writes produce no response.
- Response FIFO:
  - rsp_vld = ~empty; rsp_data = head entry.
  - Pop on rsp_vld & rsp_rdy.
  - Simultaneous push and pop leaves the count unchanged.
  - Overflow is impossible by construction; an overflow is a bench assertion failure.
  - rsp_data holds its value while rsp_vld=1 and rsp_rdy=0.
- Ordering and throughput:
  - A read issued the cycle after a write to the same address returns the new data (macro is write-then-read).
  - Sustained back-to-back reads with rsp_rdy=1 run at 1 per cycle when RSP_DEPTH>=4.

Test Plan:
- Reset release with INIT_EN=1 -> sram_cen=0 for exactly 1024 cycles, addresses 0..1023, d=0, gwen=0, wen=0. Then init_done=1 and req_rdy=1. Read of addr 5 returns 0.
- Write addr 0x3FF, data 0x0123456789ABCDEF, wstrb 0xFF; then read 0x3FF -> rsp_vld 2 cycles after the read fire, rsp_data=0x0123456789ABCDEF.
- Write addr 10, data all Fs, wstrb 0xFF; then write addr 10, data 0, wstrb 0x0F; read addr 10 -> rsp_data=0xFFFFFFFF00000000. The second write shows sram_wen=0xFFFFFFFF00000000.
- Hold rsp_rdy=0 and issue 6 reads to addresses 1..6 -> exactly 4 accepted, req_rdy drops for reads, and writes are still accepted. Release rsp_rdy -> data returned in address order 1..6, with no loss or duplication.
- Back-to-back reads of 100 addresses with rsp_rdy=1 -> one request accepted per cycle, and data returned in order.
- Assert RST with 2 reads pending and the FIFO non-empty -> rsp_vld=0 and sram_cen=1 immediately (asynchronous). After release the bench sees INIT restart from address 0 and no stale responses.
